// File: rtl/spi_handler_flash.sv
// SPI read engine for an SST25VF010A-class flash: READ command, 24-bit address, N bytes into a flat array.
// Build option SPI_FLASH_FAST_READ_EN selects FAST READ (0x0B) with one dummy byte before data.
module spi_handler_flash #(
    parameter int unsigned G_MAX_BYTES = 4096
) (
    input  logic                     i_sys_clk,
    input  logic                     i_reset_n,
    input  logic [7:0]               i_g_addr_max_width,
    input  logic                     i_data_request,
    input  logic [23:0]              i_read_addr,
    input  logic [11:0]              i_read_num,
    output logic                     o_data_ready,
    output logic                     o_command_error,
    output logic [8*G_MAX_BYTES-1:0] o_data,
    input  logic                     i_spi_clk,
    output logic                     o_spi_cs_n,
    output logic                     o_spi_si,
    input  logic                     i_spi_so
);
    localparam int unsigned NW = 13;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] READ_CMD = 8'h0B;
`else
    localparam logic [7:0] READ_CMD = 8'h03;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_START, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_STOP, S_DONE, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic          sck_q, sck_p, sck_fall, sck_rise;
    logic [23:0]   addr_q, addr_nx;
    logic [NW-1:0] num_q, num_nx, idx_q, idx_nx, num_clamp;
    logic [31:0]   tx_q, tx_nx;
    logic [4:0]    cnt_q, cnt_nx;
    logic [7:0]    rx_q, rx_nx, byte_c;
    logic [2:0]    bit_q, bit_nx;
    logic          cs_n_nx, si_nx, ready_nx, err_nx;
    logic          clr_data, wr_byte, active;

    // SCK is sampled as data; edges are seen one sys cycle after the registered change
    assign sck_fall  = sck_p & ~sck_q;
    assign sck_rise  = ~sck_p & sck_q;
    assign byte_c    = {rx_q[6:0], i_spi_so};
    assign num_clamp = (32'(i_read_num) > G_MAX_BYTES) ? NW'(G_MAX_BYTES) : NW'(i_read_num);
    assign active    = (state == S_CHECK) || (state == S_START) || (state == S_CMD) ||
                       (state == S_ADDR) || (state == S_DUMMY) || (state == S_DATA) ||
                       (state == S_STOP);

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        num_nx   = num_q;
        idx_nx   = idx_q;
        tx_nx    = tx_q;
        cnt_nx   = cnt_q;
        rx_nx    = rx_q;
        bit_nx   = bit_q;
        cs_n_nx  = o_spi_cs_n;
        si_nx    = o_spi_si;
        ready_nx = o_data_ready;
        err_nx   = o_command_error;
        clr_data = 1'b0;
        wr_byte  = 1'b0;
        case (state)
            S_IDLE: if (i_data_request && !o_data_ready && !o_command_error) begin
                addr_nx  = i_read_addr;
                num_nx   = num_clamp;
                idx_nx   = '0;
                clr_data = 1'b1;
                state_nx = S_CHECK;
            end
            S_CHECK: if ((num_q == '0) || (|(addr_q >> i_g_addr_max_width))) begin
                err_nx   = 1'b1;
                ready_nx = 1'b1;
                state_nx = S_ERR;
            end else begin
                tx_nx    = {READ_CMD, addr_q};
                state_nx = S_START;
            end
            S_START: if (sck_fall) begin
                cs_n_nx  = 1'b0;
                si_nx    = tx_q[31];
                tx_nx    = {tx_q[30:0], 1'b0};
                cnt_nx   = 5'd7;
                state_nx = S_CMD;
            end
            S_CMD: if (sck_fall) begin
                si_nx = tx_q[31];
                tx_nx = {tx_q[30:0], 1'b0};
                if (cnt_q == 5'd1) begin
                    cnt_nx   = 5'd24;
                    state_nx = S_ADDR;
                end else begin
                    cnt_nx = cnt_q - 5'd1;
                end
            end
            // the fall after the last address bit hands the bus to the device
            S_ADDR: if (sck_fall) begin
                if (cnt_q == 5'd0) begin
                    si_nx  = 1'b0;
                    bit_nx = 3'd0;
`ifdef SPI_FLASH_FAST_READ_EN
                    cnt_nx   = 5'd7;
                    state_nx = S_DUMMY;
`else
                    state_nx = S_DATA;
`endif
                end else begin
                    si_nx  = tx_q[31];
                    tx_nx  = {tx_q[30:0], 1'b0};
                    cnt_nx = cnt_q - 5'd1;
                end
            end
            S_DUMMY: if (sck_fall) begin
                if (cnt_q == 5'd0) state_nx = S_DATA;
                else               cnt_nx   = cnt_q - 5'd1;
            end
            S_DATA: if (sck_rise) begin
                rx_nx  = byte_c;
                bit_nx = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    wr_byte = 1'b1;
                    idx_nx  = idx_q + NW'(1);
                    if ((idx_q + NW'(1)) == num_q) state_nx = S_STOP;
                end
            end
            S_STOP: if (sck_fall) begin
                cs_n_nx  = 1'b1;
                si_nx    = 1'b0;
                state_nx = S_DONE;
            end
            S_DONE: begin
                ready_nx = 1'b1;
                if (!i_data_request) begin
                    ready_nx = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            S_ERR: if (!i_data_request) begin
                err_nx   = 1'b0;
                ready_nx = 1'b0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // request withdrawn mid-transfer: release the bus, keep bytes already stored
        if (active && !i_data_request) begin
            cs_n_nx  = 1'b1;
            si_nx    = 1'b0;
            wr_byte  = 1'b0;
            idx_nx   = idx_q;
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= S_IDLE;
            sck_q           <= 1'b1;
            sck_p           <= 1'b1;
            addr_q          <= '0;
            num_q           <= '0;
            idx_q           <= '0;
            tx_q            <= '0;
            cnt_q           <= '0;
            rx_q            <= '0;
            bit_q           <= '0;
            o_spi_cs_n      <= 1'b1;
            o_spi_si        <= 1'b0;
            o_data_ready    <= 1'b0;
            o_command_error <= 1'b0;
            o_data          <= '0;
        end else begin
            state           <= state_nx;
            sck_q           <= i_spi_clk;
            sck_p           <= sck_q;
            addr_q          <= addr_nx;
            num_q           <= num_nx;
            idx_q           <= idx_nx;
            tx_q            <= tx_nx;
            cnt_q           <= cnt_nx;
            rx_q            <= rx_nx;
            bit_q           <= bit_nx;
            o_spi_cs_n      <= cs_n_nx;
            o_spi_si        <= si_nx;
            o_data_ready    <= ready_nx;
            o_command_error <= err_nx;
            if (clr_data)     o_data                       <= '0;
            else if (wr_byte) o_data[8*32'(idx_q) +: 8]    <= byte_c;
        end
    end
endmodule

// File: tb/tb_spi_handler_flash.sv
// Bench for spi_handler_flash: behavioural 128 KB flash plus a scoreboard of expected byte arrays.
module tb_spi_handler_flash;
    localparam int unsigned MB = 32;
    localparam int unsigned DW = 8*MB;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] EXP_CMD = 8'h0B;
    localparam int         HDR     = 40;
`else
    localparam logic [7:0] EXP_CMD = 8'h03;
    localparam int         HDR     = 32;
`endif

    logic          sys_clk = 1'b0;
    logic          spi_clk = 1'b1;
    logic          rst_n = 1'b0;
    logic          data_request = 1'b0;
    logic [23:0]   read_addr = '0;
    logic [11:0]   read_num = '0;
    logic          data_ready, cmd_err, cs_n, si;
    logic          so = 1'b0;
    logic [DW-1:0] data;

    int checks = 0;
    int errors = 0;

    spi_handler_flash #(.G_MAX_BYTES(MB)) dut (
        .i_sys_clk(sys_clk), .i_reset_n(rst_n), .i_g_addr_max_width(8'd17),
        .i_data_request(data_request), .i_read_addr(read_addr), .i_read_num(read_num),
        .o_data_ready(data_ready), .o_command_error(cmd_err), .o_data(data),
        .i_spi_clk(spi_clk), .o_spi_cs_n(cs_n), .o_spi_si(si), .i_spi_so(so)
    );

    always #5 sys_clk = ~sys_clk;
    initial begin
        #3;
        forever #40 spi_clk = ~spi_clk;
    end

    function automatic logic [7:0] mem_byte(input logic [16:0] a);
        logic [31:0] x;
        x = {15'd0, a};
        return 8'((x * 32'd37) ^ (x >> 7) ^ 32'h5A);
    endfunction

    // flash model: mode 3, samples SI on rising SCK, shifts SO out on falling SCK, wraps at 128 KB
    int          rx_cnt = 0;
    int          tx_cnt = 0;
    logic [39:0] hdr_sr = '0;
    logic [7:0]  f_cmd = '0;
    logic [23:0] f_addr = '0;
    logic        cs_low_seen = 1'b0;

    always @(posedge cs_n) begin
        rx_cnt = 0;
        tx_cnt = 0;
    end
    always @(negedge cs_n) cs_low_seen = 1'b1;
    always @(posedge spi_clk) begin
        if (!cs_n && rx_cnt < HDR) begin
            hdr_sr = {hdr_sr[38:0], si};
            rx_cnt++;
            if (rx_cnt == 32) begin
                f_cmd  = hdr_sr[31:24];
                f_addr = hdr_sr[23:0];
            end
        end
    end
    always @(negedge spi_clk) begin
        logic [7:0] b;
        if (!cs_n && rx_cnt == HDR) begin
            b  = mem_byte(17'(f_addr + 24'(tx_cnt / 8)));
            so = b[7 - (tx_cnt % 8)];
            tx_cnt++;
        end
    end

    typedef struct {
        logic          err;
        logic [23:0]   addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [23:0] addr, input logic [11:0] num);
        exp_t e;
        int   n;
        bit   done;
        e.err  = (num == 12'd0) || (addr[23:17] != 7'd0);
        e.addr = addr;
        e.data = '0;
        n = (32'(num) > MB) ? int'(MB) : int'(num);
        if (!e.err)
            for (int i = 0; i < n; i++) e.data[8*i +: 8] = mem_byte(17'(addr + 24'(i)));
        sb_q.push_back(e);
        @(negedge sys_clk);
        cs_low_seen  = 1'b0;
        f_cmd        = 8'h00;
        f_addr       = 24'hFFFFFF;
        read_addr    = addr;
        read_num     = num;
        data_request = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge sys_clk);
            if (data_ready) done = 1'b1;
        end
        e = sb_q.pop_front();
        if (!done) begin
            check("ready_timeout", DW'(data_ready), DW'(1));
        end else begin
            check("error_flag", DW'(cmd_err), DW'(e.err));
            check("data", data, e.data);
            check("cs_idle", DW'(cs_n), DW'(1));
            if (e.err) begin
                check("cs_quiet", DW'(cs_low_seen), DW'(0));
            end else begin
                check("flash_cmd", DW'(f_cmd), DW'(EXP_CMD));
                check("flash_addr", DW'(f_addr), DW'(e.addr));
            end
            repeat (3) @(negedge sys_clk);
            check("ready_hold", DW'(data_ready), DW'(1));
            check("data_hold", data, e.data);
        end
        data_request = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("ready_clr", DW'(data_ready), DW'(0));
        check("err_clr", DW'(cmd_err), DW'(0));
        repeat (4) @(negedge sys_clk);
    endtask

    // start a request and return once chip select has gone low (bounded)
    task automatic start_and_wait_cs(input logic [23:0] addr, input logic [11:0] num);
        bit seen;
        @(negedge sys_clk);
        read_addr    = addr;
        read_num     = num;
        data_request = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge sys_clk);
            if (!cs_n) seen = 1'b1;
        end
        check("cs_low", DW'(cs_n), DW'(0));
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_ready", DW'(data_ready), DW'(0));
        check("rst_err", DW'(cmd_err), DW'(0));
        check("rst_data", data, '0);
        check("rst_cs", DW'(cs_n), DW'(1));
        check("rst_si", DW'(si), DW'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        do_req(24'h000005, 12'd16);
        do_req(24'h000000, 12'd24);
        do_req(24'h000000, 12'd4);
        do_req(24'h01FFFC, 12'd16);
        do_req(24'h020000, 12'd8);
        do_req(24'h000100, 12'd0);
        do_req(24'h000010, 12'd40);
        do_req(24'h01FFFF, 12'd1);

        // abort: dropping the request mid-transfer releases CS right away
        start_and_wait_cs(24'h000040, 12'd8);
        #2000;
        @(negedge sys_clk);
        data_request = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("abort_cs", DW'(cs_n), DW'(1));
        check("abort_ready", DW'(data_ready), DW'(0));
        repeat (4) @(negedge sys_clk);

        // asynchronous reset in the data phase
        start_and_wait_cs(24'h000080, 12'd8);
        #3200;
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs", DW'(cs_n), DW'(1));
        check("arst_si", DW'(si), DW'(0));
        check("arst_ready", DW'(data_ready), DW'(0));
        check("arst_err", DW'(cmd_err), DW'(0));
        check("arst_data", data, '0);
        data_request = 1'b0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        do_req(24'h001234, 12'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
